mat_serializer: RTL and testbench
=================================

// Module: mat_serializer
// PURPOSE
//   Drain side of the float matrix datapath: captures one packed ROWS x COLS float matrix (as produced
//   by the combinational matrix multiplier) and streams it out one element per beat over a
//   valid/ready interface, row-major or column-major. Feeds narrow consumers (FIFOs, DMA, UART bridges)
//   that cannot take a full matrix bus; throughput ROWS*COLS beats per matrix, no bubbles back-to-back.
// PARAMETERS
//   EXP_BITS   8    exponent field width (from `FLOAT_BIAS_PARAMS)
//   MANT_BITS  23   mantissa field width (from `FLOAT_BIAS_PARAMS)
//   BIAS       127  exponent bias (from `FLOAT_BIAS_PARAMS; carried, unused internally)
//   ROWS       4    matrix rows, >= 1
//   COLS       4    matrix columns, >= 1
//   FW = 1+EXP_BITS+MANT_BITS (element width); RW/CW = max(1,$clog2(ROWS/COLS)) (derived localparams)
// PORTS
//   clk           in   1               rising-edge clock
//   rst_n         in   1               asynchronous active-low reset
//   in_valid      in   1               packed matrix present on in_mat
//   in_ready      out  1               block can accept a matrix this cycle
//   in_mat        in   FW*ROWS*COLS    element (r,c) at in_mat[(r*COLS+c)*FW +: FW] (MAT_SELECT layout)
//   in_col_major  in   1               order for this matrix: 0 row-major, 1 column-major; sampled on accept
//   out_valid     out  1               out_data/out_row/out_col/out_last valid
//   out_ready     in   1               consumer accepts beat
//   out_data      out  FW              current element, bit-exact copy (no float interpretation)
//   out_row       out  RW              row index of current element
//   out_col       out  CW              column index of current element
//   out_last      out  1               current element is final of the matrix
// BEHAVIOUR
//   - States: IDLE (no matrix held), SEND (matrix held, beats outstanding).
//   - Reset (rst_n=0, async): state=IDLE, out_valid=0, row/col counters=0, order=0; buffer contents
//     don't-care. Hence in_ready=1, out_last=0, out_data = buffer[0] (don't-care) while in reset.
//   - in_ready = (state==IDLE) | (out_valid & out_ready & out_last); combinational, no in_valid dependency.
//   - Accept (in_valid & in_ready at edge): buffer<=in_mat, order<=in_col_major, row<=0, col<=0,
//     state<=SEND, out_valid<=1. Latency: first beat valid the cycle after accept.
//   - Beat transfer = out_valid & out_ready. Row-major: col increments, wraps to 0 at COLS-1 with row+1.
//     Column-major: row increments, wraps to 0 at ROWS-1 with col+1.
//   - out_last = out_valid & (row==ROWS-1) & (col==COLS-1), either order.
//   - Last beat transferred with no concurrent accept: state<=IDLE, out_valid<=0, counters<=0.
//   - Last beat transferred with concurrent accept: reload per Accept rule; out_valid stays 1 (no bubble).
//   - Stall: out_valid & !out_ready holds out_data/out_row/out_col/out_last stable; in_ready=0.
//   - out_valid never deasserts before its beat transfers; in_mat ignored when in_ready=0.
//   - out_data = buffer element at (row,col), muxed combinationally from registered state only.
//   - ROWS=COLS=1: every beat is last; one beat per matrix, back-to-back accept each cycle allowed.
//   - Reset mid-matrix: remaining beats discarded; no partial output after rst_n release.
// STRUCTURE
//   - FW/MAT_WIDTH/MAT_SELECT/VEC_SELECT macros and FLOAT_BIAS_PARAMS come from shared mat_macros.vh;
//     no new shared constants required.
//   - One sub-module: mat_index_counter (ROWS, COLS params; inputs clr, step, col_major; outputs
//     row, col, at_end). Top holds buffer, state, handshake logic and output mux.
// TESTING (defaults FW=32 unless noted; ROWS=2, COLS=3 benches)
//   - Row-major, out_ready=1: accept elements e0..e5 = 32'h3F800000+i -> 6 beats, cycles 1..6
//     after accept, data e0..e5, (row,col)=(0,0),(0,1),(0,2),(1,0),(1,1),(1,2), out_last only on 6th.
//   - Column-major same matrix -> order e0,e3,e1,e4,e2,e5; (row,col)=(0,0),(1,0),(0,1),(1,1),(0,2),(1,2).
//   - Backpressure: out_ready toggles 1,0,0,1... -> outputs stable during stalls, no beat lost or
//     duplicated, in_ready=0 until last beat handshake.
//   - Back-to-back: in_valid held high with matrix B during A's last beat -> B's first beat valid
//     next cycle, out_valid never drops, 12 beats in 12 consecutive out_ready=1 cycles.
//   - Reset mid-matrix: rst_n low after beat 2 -> out_valid=0 immediately (async), in_ready=1; after
//     release new matrix streams from (0,0).
//   - ROWS=COLS=1: stream 3 matrices with in_valid/out_ready constantly 1 -> one beat per cycle,
//     out_last=1 on every beat.

Source files
------------

// File: rtl/mat_serializer_pkg.sv
// Shared types and helpers for the matrix serializer slice.
//   state_e  : serializer control state (idle / sending a held matrix)
//   idx_bits : width of an index register for a dimension of n entries (min 1)
package mat_serializer_pkg;

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_e;

  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mat_serializer_index_counter.sv
// Row/column walker for the matrix serializer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force row/col back to (0,0) (takes priority over step)
//   step       : advance one element in the selected order
//   col_major  : 0 row-major (col fastest), 1 column-major (row fastest)
//   row, col   : current element coordinates
//   at_end     : current element is (ROWS-1, COLS-1)
module mat_index_counter
  import mat_serializer_pkg::*;
#(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4,
  localparam int unsigned RW  = idx_bits(ROWS),
  localparam int unsigned CW  = idx_bits(COLS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          step,
  input  logic          col_major,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          at_end
);

  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (step) begin
      if (col_major) begin
        if (row_q == ROW_MAX) begin
          row_d = '0;
          col_d = (col_q == COL_MAX) ? '0 : col_q + CW'(1);
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        if (col_q == COL_MAX) begin
          col_d = '0;
          row_d = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row    = row_q;
  assign col    = col_q;
  assign at_end = (row_q == ROW_MAX) && (col_q == COL_MAX);

endmodule

// File: rtl/mat_serializer.sv
// Captures one packed ROWS x COLS float matrix and streams it out one element
// per beat over valid/ready, row-major or column-major per matrix.
//   clk, rst_n    : clock, asynchronous active-low reset
//   in_valid/in_ready/in_mat/in_col_major : matrix input handshake; element
//                   (r,c) at in_mat[(r*COLS+c)*FW +: FW]; order sampled on accept
//   out_valid/out_ready : element output handshake
//   out_data      : current element (bit-exact)
//   out_row/out_col : coordinates of current element
//   out_last      : current element is the final one of the matrix
module mat_serializer
  import mat_serializer_pkg::*;
#(
  parameter int unsigned EXP_BITS  = 8,
  parameter int unsigned MANT_BITS = 23,
  parameter int unsigned BIAS      = 127,
  parameter int unsigned ROWS      = 4,
  parameter int unsigned COLS      = 4,
  localparam int unsigned FW       = 1 + EXP_BITS + MANT_BITS,
  localparam int unsigned RW       = idx_bits(ROWS),
  localparam int unsigned CW       = idx_bits(COLS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FW*ROWS*COLS-1:0] in_mat,
  input  logic                   in_col_major,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FW-1:0]          out_data,
  output logic [RW-1:0]          out_row,
  output logic [CW-1:0]          out_col,
  output logic                   out_last
);

  localparam int unsigned NELEM = ROWS * COLS;
  localparam int unsigned IW    = idx_bits(NELEM);

  if (ROWS < 1 || COLS < 1 || BIAS >= (1 << EXP_BITS)) begin : g_param_check
    $error("mat_serializer: invalid ROWS/COLS/BIAS");
  end

  state_e        state_q, state_d;
  logic          order_q, order_d;
  logic [FW-1:0] elem_q [NELEM];

  logic          at_end;
  logic          beat;
  logic          last_beat;
  logic          accept;
  logic          cnt_clr;
  logic [IW-1:0] idx;

  // in_ready opens on the final beat so a new matrix reloads without a bubble.
  always_comb begin
    state_d   = state_q;
    order_d   = order_q;
    out_valid = (state_q == S_SEND);
    beat      = out_valid & out_ready;
    last_beat = beat & at_end;
    in_ready  = (state_q == S_IDLE) | last_beat;
    accept    = in_valid & in_ready;
    cnt_clr   = accept | last_beat;
    if (accept) begin
      state_d = S_SEND;
      order_d = in_col_major;
    end else if (last_beat) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      order_q <= 1'b0;
    end else begin
      state_q <= state_d;
      order_q <= order_d;
    end
  end

  // Buffer contents are don't-care until a matrix is accepted, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned i = 0; i < NELEM; i++) begin
        elem_q[i] <= in_mat[i*FW +: FW];
      end
    end
  end

  mat_index_counter #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_idx (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cnt_clr),
    .step      (beat),
    .col_major (order_q),
    .row       (out_row),
    .col       (out_col),
    .at_end    (at_end)
  );

  always_comb begin
    idx      = IW'(out_row) * IW'(COLS) + IW'(out_col);
    out_data = elem_q[idx];
    out_last = out_valid & at_end;
  end

endmodule

// File: tb/tb_mat_serializer.sv
module tb_mat_serializer;

  localparam int R  = 2;
  localparam int C  = 3;
  localparam int N  = R * C;
  localparam int FW = 32;

  typedef struct {
    logic [31:0] d;
    int          r;
    int          c;
    bit          last;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [FW*N-1:0] in_mat = '0;
  logic            in_col_major = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [FW-1:0]   out_data;
  logic [0:0]      out_row;
  logic [1:0]      out_col;
  logic            out_last;

  logic            s_in_valid = 1'b0;
  logic            s_in_ready;
  logic [FW-1:0]   s_in_mat = '0;
  logic            s_out_valid;
  logic            s_out_ready = 1'b0;
  logic [FW-1:0]   s_out_data;
  logic [0:0]      s_out_row;
  logic [0:0]      s_out_col;
  logic            s_out_last;

  int errs   = 0;
  int checks = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  mat_serializer #(
    .EXP_BITS (8), .MANT_BITS (23), .BIAS (127), .ROWS (R), .COLS (C)
  ) dut (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (in_ready),
    .in_mat (in_mat), .in_col_major (in_col_major), .out_valid (out_valid),
    .out_ready (out_ready), .out_data (out_data), .out_row (out_row),
    .out_col (out_col), .out_last (out_last)
  );

  mat_serializer #(
    .EXP_BITS (8), .MANT_BITS (23), .BIAS (127), .ROWS (1), .COLS (1)
  ) dut1 (
    .clk (clk), .rst_n (rst_n), .in_valid (s_in_valid), .in_ready (s_in_ready),
    .in_mat (s_in_mat), .in_col_major (1'b0), .out_valid (s_out_valid),
    .out_ready (s_out_ready), .out_data (s_out_data), .out_row (s_out_row),
    .out_col (s_out_col), .out_last (s_out_last)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected beat sequence of a whole matrix, enumerated in the requested order.
  task automatic push_matrix(input logic [FW*N-1:0] m, input bit cm);
    beat_t b;
    for (int k = 0; k < N; k++) begin
      b.r    = cm ? (k % R) : (k / C);
      b.c    = cm ? (k / R) : (k % C);
      b.d    = m[(b.r*C + b.c)*FW +: FW];
      b.last = (k == N - 1);
      exp_q.push_back(b);
    end
  endtask

  // One clock: drive at the falling edge, check settled outputs, predict the rising edge.
  task automatic cycle(input bit iv, input logic [FW*N-1:0] m, input bit cm, input bit ordy);
    bit exp_v, exp_rdy;
    @(negedge clk);
    in_valid     = iv;
    in_mat       = m;
    in_col_major = cm;
    out_ready    = ordy;
    #1;
    exp_v = (exp_q.size() != 0);
    check("out_valid", 64'(out_valid), 64'(exp_v));
    if (exp_v) begin
      check("out_data", 64'(out_data), 64'(exp_q[0].d));
      check("out_row",  64'(out_row),  64'(exp_q[0].r));
      check("out_col",  64'(out_col),  64'(exp_q[0].c));
      check("out_last", 64'(out_last), 64'(exp_q[0].last));
    end else begin
      check("out_last_idle", 64'(out_last), 64'(0));
    end
    exp_rdy = !exp_v || (ordy && exp_q[0].last);
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (exp_v && ordy) void'(exp_q.pop_front());
    if (iv && exp_rdy) push_matrix(m, cm);
  endtask

  function automatic logic [FW*N-1:0] rand_mat();
    logic [FW*N-1:0] m;
    for (int i = 0; i < N; i++) m[i*FW +: FW] = $urandom;
    return m;
  endfunction

  logic [FW*N-1:0] ma, mb;
  logic [FW-1:0]   prev1;
  bit              ob[4];

  initial begin
    for (int i = 0; i < N; i++) ma[i*FW +: FW] = 32'h3F800000 + i;
    mb = rand_mat();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_out_last",  64'(out_last),  64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Row-major then column-major, consumer always ready
    cycle(1, ma, 0, 1);
    repeat (N) cycle(0, '0, 0, 1);
    cycle(1, ma, 1, 1);
    repeat (N) cycle(0, '0, 0, 1);
    cycle(0, '0, 0, 1);

    // Backpressure: out_ready 1,0,0 repeating
    cycle(1, mb, 0, 1);
    for (int i = 0; i < 3 * N + 3; i++) cycle(0, '0, 0, (i % 3) == 0);
    cycle(0, '0, 0, 1);

    // Back-to-back: in_valid held high, matrix B offered throughout A
    cycle(1, ma, 0, 1);
    for (int i = 0; i < N; i++) cycle(1, mb, 1, 1);
    repeat (N + 1) cycle(0, '0, 0, 1);

    // Reset after two beats
    cycle(1, mb, 0, 1);
    cycle(0, '0, 0, 1);
    cycle(0, '0, 0, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_in_ready",  64'(in_ready),  64'(1));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, '0, 0, 1);
    cycle(1, ma, 1, 1);
    repeat (N + 1) cycle(0, '0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) == 0, rand_mat(), $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) < 7);
    repeat (3 * N) cycle(0, '0, 0, 1);

    // 1x1 instance: one beat per cycle, every beat last
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s_in_valid  = (i < 4);
      s_out_ready = 1'b1;
      s_in_mat    = $urandom;
      #1;
      check("s1_out_valid", 64'(s_out_valid), 64'(i > 0));
      check("s1_in_ready",  64'(s_in_ready),  64'(1));
      if (i > 0) begin
        check("s1_out_data", 64'(s_out_data), 64'(prev1));
        check("s1_out_last", 64'(s_out_last), 64'(1));
      end
      prev1 = s_in_mat;
    end
    @(negedge clk);
    s_in_valid = 1'b0;
    #1;
    check("s1_drained", 64'(s_out_valid), 64'(0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
